// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared key codes, debounce states and scan helpers
// Purpose : constants shared by the keypad scanner, its keymap LUT and the bench.
// Contents: KEY_0..KEY_F / KEY_NONE codes, ks_state_e debounce states,
//           first_low_col() column priority encoder.
package keypad_scanner_pkg;

   localparam logic [4:0] KEY_0    = 5'h00;
   localparam logic [4:0] KEY_1    = 5'h01;
   localparam logic [4:0] KEY_2    = 5'h02;
   localparam logic [4:0] KEY_3    = 5'h03;
   localparam logic [4:0] KEY_4    = 5'h04;
   localparam logic [4:0] KEY_5    = 5'h05;
   localparam logic [4:0] KEY_6    = 5'h06;
   localparam logic [4:0] KEY_7    = 5'h07;
   localparam logic [4:0] KEY_8    = 5'h08;
   localparam logic [4:0] KEY_9    = 5'h09;
   localparam logic [4:0] KEY_A    = 5'h0A;
   localparam logic [4:0] KEY_B    = 5'h0B;
   localparam logic [4:0] KEY_C    = 5'h0C;
   localparam logic [4:0] KEY_D    = 5'h0D;
   localparam logic [4:0] KEY_E    = 5'h0E;
   localparam logic [4:0] KEY_F    = 5'h0F;
   localparam logic [4:0] KEY_NONE = 5'h10;

   typedef enum logic [1:0] {
      KS_IDLE       = 2'd0,
      KS_DB_PRESS   = 2'd1,
      KS_HELD       = 2'd2,
      KS_DB_RELEASE = 2'd3
   } ks_state_e;

   // Lowest-numbered active-low column; returns 0 when none is low,
   // callers qualify with their own "any column low" test.
   function automatic logic [1:0] first_low_col(input logic [3:0] col_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!col_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and debounced key bus
// Purpose : bundles the matrix wires and the key output bus.
// Signals : col (4, active-low, from keypad), row (4, active-low one-hot drive),
//           key (5, debounced code), key_strobe (1-clk pulse per accepted press).
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;

   logic [3:0] col;
   logic [3:0] row;
   logic [4:0] key;
   logic       key_strobe;

   modport master (input col, output row, output key, output key_strobe);
   modport slave  (output col, input row, input key, input key_strobe);

endinterface

// File: rtl/keypad_scanner_keymap.sv
// rtl/keypad_scanner_keymap.sv - combinational {row,col} to key code LUT
// Purpose : maps a matrix position to its key code.
// Ports   : row_idx_i (2) row index, col_idx_i (2) column index, code_o (5) key code.
//           Layout  row0: 1 2 3 A | row1: 4 5 6 B | row2: 7 8 9 C | row3: E 0 F D
module keypad_keymap
   import keypad_scanner_pkg::*;
(
   input  logic [1:0] row_idx_i,
   input  logic [1:0] col_idx_i,
   output logic [4:0] code_o
);

   always_comb begin
      code_o = KEY_NONE;
      case ({row_idx_i, col_idx_i})
         4'd0:  code_o = KEY_1;
         4'd1:  code_o = KEY_2;
         4'd2:  code_o = KEY_3;
         4'd3:  code_o = KEY_A;
         4'd4:  code_o = KEY_4;
         4'd5:  code_o = KEY_5;
         4'd6:  code_o = KEY_6;
         4'd7:  code_o = KEY_B;
         4'd8:  code_o = KEY_7;
         4'd9:  code_o = KEY_8;
         4'd10: code_o = KEY_9;
         4'd11: code_o = KEY_C;
         4'd12: code_o = KEY_E;
         4'd13: code_o = KEY_0;
         4'd14: code_o = KEY_F;
         4'd15: code_o = KEY_D;
         default: code_o = KEY_NONE;
      endcase
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce
// Purpose : drives rows, samples synchronized columns, debounces whole scans
//           and presents a level key code plus a strobe per accepted press.
// Ports   : clk (system clock), rst (asynchronous, active-low reset),
//           kp (keypad_scanner_if.master: col in, row/key/key_strobe out).
// Option  : KEYPAD_AUTOREPEAT_EN adds repeat strobes while a key stays held
//           (REPEAT_DELAY_SCANS to the first, REPEAT_SCANS between later ones).
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY_SCANS = 64,
   parameter int REPEAT_SCANS       = 16
`endif
)
(
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master kp
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   logic [3:0]       col_s1_q, col_s2_q;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       row_idx_q;
   logic [3:0]       row_q;
   logic [4:0]       acc_q;

   logic             tick, scan_end, col_any;
   logic [1:0]       col_idx;
   logic [4:0]       lut_code, row_code, raw;

   ks_state_e        state_q, state_d;
   logic [4:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [4:0]       key_q, key_d;
   logic             strobe_q, strobe_d;

   assign tick     = (div_q == DIV_LAST);
   assign scan_end = tick && (row_idx_q == 2'd3);
   assign col_any  = (col_s2_q != 4'hF);
   assign col_idx  = first_low_col(col_s2_q);

   keypad_keymap u_keymap (
      .row_idx_i (row_idx_q),
      .col_idx_i (col_idx),
      .code_o    (lut_code)
   );

   assign row_code = col_any ? lut_code : KEY_NONE;
   // Lowest row wins: once a row has produced a code the later rows are ignored.
   assign raw      = (acc_q != KEY_NONE) ? acc_q : row_code;

   // Synchronizer, prescaler, row walker and scan accumulator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1_q  <= 4'hF;
         col_s2_q  <= 4'hF;
         div_q     <= '0;
         row_idx_q <= 2'd0;
         row_q     <= 4'b1110;
         acc_q     <= KEY_NONE;
      end else begin
         col_s1_q <= kp.col;
         col_s2_q <= col_s1_q;
         if (tick) begin
            div_q     <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= ~(4'b0001 << (row_idx_q + 2'd1));
            // raw is consumed by the FSM on scan_end; start the next scan empty.
            acc_q     <= scan_end ? KEY_NONE : raw;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   assign cnt_inc = (cnt_q < CNT_DONE) ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [15:0] rep_cnt_q, rep_cnt_d, rep_next;
   logic        rep_armed_q, rep_armed_d;
   assign rep_next = rep_cnt_q + 16'd1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= KS_IDLE;
         cand_q   <= KEY_NONE;
         cnt_q    <= '0;
         key_q    <= KEY_NONE;
         strobe_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      strobe_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
`endif
      if (scan_end) begin
         case (state_q)
            KS_IDLE: begin
               if (raw != KEY_NONE) begin
                  state_d = KS_DB_PRESS;
                  cand_d  = raw;
                  cnt_d   = CNT_W'(1);
               end
            end
            KS_DB_PRESS: begin
               if (raw == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state_d  = KS_HELD;
                     key_d    = cand_q;
                     strobe_d = 1'b1;
                  end
               end else if (raw == KEY_NONE) begin
                  state_d = KS_IDLE;
                  cnt_d   = '0;
               end else begin
                  cand_d = raw;
                  cnt_d  = CNT_W'(1);
               end
            end
            KS_HELD: begin
               if (raw != key_q) begin
                  state_d = KS_DB_RELEASE;
                  cand_d  = raw;
                  cnt_d   = CNT_W'(1);
               end
            end
            KS_DB_RELEASE: begin
               if (raw == key_q) begin
                  state_d = KS_HELD;
               end else if (raw == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     key_d = cand_q;
                     if (cand_q == KEY_NONE) begin
                        state_d = KS_IDLE;
                     end else begin
                        state_d  = KS_HELD;
                        strobe_d = 1'b1;
                     end
                  end
               end else begin
                  cand_d = raw;
                  cnt_d  = CNT_W'(1);
               end
            end
            default: state_d = KS_IDLE;
         endcase
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      // Any entry into or exit from KS_HELD restarts the initial delay.
      if ((state_q != KS_HELD) || (state_d != KS_HELD)) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b0;
      end else if (scan_end) begin
         if (rep_next == (rep_armed_q ? 16'(REPEAT_SCANS) : 16'(REPEAT_DELAY_SCANS))) begin
            strobe_d    = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
         end else begin
            rep_cnt_d = rep_next;
         end
      end
`endif
   end

   assign kp.row        = row_q;
   assign kp.key        = key_q;
   assign kp.key_strobe = strobe_q;

endmodule
